// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner with per-frame input snapshot, dead time and blink.
// Latency: outputs registered, reflecting the scan state one cycle after it is left; no backpressure.
module seg_scan #(
    parameter int PRESCALE       = 8,
    parameter int DEAD           = 1,
    parameter int BLINK_FRAMES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        scan_clk_i,
    input  logic        reset_n_i,
    input  logic [15:0] digits_i,
    input  logic [3:0]  dp_in_i,
    input  logic [3:0]  blink_mask_i,
    input  logic        blink_en_i,
    output logic [6:0]  seg_out_o,
    output logic        dp_out_o,
    output logic [3:0]  dig_sel_o,
    output logic        frame_start_o
);

    localparam int DIV_W = $clog2(PRESCALE);
    localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);
    localparam logic [DIV_W:0]   LIT_END  = (DIV_W + 1)'(PRESCALE - DEAD);
    localparam logic [BF_W-1:0]  BF_LAST  = BF_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]       SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic             DP_OFF   = SEG_ACTIVE_LOW;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Scan position, blink phase and per-frame snapshot.
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [BF_W-1:0]  fcnt_q, fcnt_d;
    logic             phase_q, phase_d;
    logic [15:0]      sh_digits_q;
    logic [3:0]       sh_dp_q;
    logic [3:0]       sh_mask_q;

    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       sel_q, sel_d;
    logic             fs_q, fs_d;

    logic             frame_head;
    logic             div_last;
    logic             frame_last;
    logic [15:0]      cur_digits;
    logic [3:0]       cur_dp;
    logic [3:0]       cur_mask;
    logic [3:0]       cur_code;
    logic             lit_win;
    logic             suppress;
    logic             lit;
    logic [6:0]       seg_act;

    always_comb begin
        frame_head = (div_q == '0) && (idx_q == 2'd0);
        div_last   = (div_q == DIV_LAST);
        frame_last = div_last && (idx_q == 2'd3);

        // The frame-start cycle decodes from the live inputs it is capturing.
        cur_digits = frame_head ? digits_i     : sh_digits_q;
        cur_dp     = frame_head ? dp_in_i      : sh_dp_q;
        cur_mask   = frame_head ? blink_mask_i : sh_mask_q;
        cur_code   = cur_digits[{idx_q, 2'b00} +: 4];

        lit_win  = ({1'b0, div_q} < LIT_END);
        suppress = blink_en_i & phase_q & cur_mask[idx_q];
        lit      = lit_win & ~suppress;

        seg_act = lit ? hex_to_seg(cur_code) : 7'h00;
        seg_d   = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
        dp_d    = (lit & cur_dp[idx_q]) ^ SEG_ACTIVE_LOW;
        sel_d   = lit ? ~(4'b0001 << idx_q) : 4'hF;
        fs_d    = frame_head;

        div_d   = div_last ? '0 : div_q + 1'b1;
        idx_d   = div_last ? idx_q + 2'd1 : idx_q;
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        // The blink phase changes only across a frame boundary.
        if (frame_last) begin
            if (fcnt_q == BF_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d  = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge scan_clk_i) begin
        if (!reset_n_i) begin
            div_q       <= '0;
            idx_q       <= 2'd0;
            fcnt_q      <= '0;
            phase_q     <= 1'b0;
            sh_digits_q <= 16'h0000;
            sh_dp_q     <= 4'h0;
            sh_mask_q   <= 4'h0;
            seg_q       <= SEG_OFF;
            dp_q        <= DP_OFF;
            sel_q       <= 4'hF;
            fs_q        <= 1'b0;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            if (frame_head) begin
                sh_digits_q <= digits_i;
                sh_dp_q     <= dp_in_i;
                sh_mask_q   <= blink_mask_i;
            end
            seg_q <= seg_d;
            dp_q  <= dp_d;
            sel_q <= sel_d;
            fs_q  <= fs_d;
        end
    end

    assign seg_out_o     = seg_q;
    assign dp_out_o      = dp_q;
    assign dig_sel_o     = sel_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_seg_scan.sv
// Randomized and directed bench for seg_scan against a frame-arithmetic reference model.
module tb_seg_scan;

    localparam int P    = 4;
    localparam int DEAD = 1;
    localparam int BF   = 2;
    localparam bit SAL  = 1'b1;
    localparam int FR   = 4 * P;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic        blink_en;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  dig_sel;
    logic        frame_start;

    always #5 clk = ~clk;

    seg_scan #(
        .PRESCALE       (P),
        .DEAD           (DEAD),
        .BLINK_FRAMES   (BF),
        .SEG_ACTIVE_LOW (SAL)
    ) dut (
        .scan_clk_i    (clk),
        .reset_n_i     (rst_n),
        .digits_i      (digits),
        .dp_in_i       (dp_in),
        .blink_mask_i  (blink_mask),
        .blink_en_i    (blink_en),
        .seg_out_o     (seg_out),
        .dp_out_o      (dp_out),
        .dig_sel_o     (dig_sel),
        .frame_start_o (frame_start)
    );

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: t counts edges taken out of reset; snapshots mimic a frame latch.
    int          t = 0;
    int          cur_idx = 0;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic [3:0]  m_mask;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_sel;
    logic        e_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        int pos, dv, f, code;
        bit lit, supp;
        @(posedge clk);
        if (!rst_n) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_sel = 4'hF; e_fs = 1'b0;
            t = 0;
        end else begin
            pos = t % FR;
            cur_idx = pos / P;
            dv  = pos % P;
            f   = t / FR;
            if (pos == 0) begin
                m_dig = digits; m_dp = dp_in; m_mask = blink_mask;
            end
            code = int'((m_dig >> (4 * cur_idx)) & 16'hF);
            supp = blink_en && (((f / BF) % 2) == 1) && m_mask[cur_idx];
            lit  = (dv < P - DEAD) && !supp;
            e_seg = lit ? ~seg_tbl[code] : 7'h7F;
            e_dp  = lit ? ~m_dp[cur_idx] : 1'b1;
            e_sel = lit ? ~(4'b0001 << cur_idx) : 4'hF;
            e_fs  = (pos == 0);
            t++;
        end
        #1;
        chk("seg_out", 32'(seg_out), 32'(e_seg));
        chk("dp_out", 32'(dp_out), 32'(e_dp));
        chk("dig_sel", 32'(dig_sel), 32'(e_sel));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("dig_sel_onehot", 32'($countones(~dig_sel) <= 1), 32'd1);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            digits = 16'($urandom); dp_in = 4'($urandom);
            blink_mask = 4'($urandom); blink_en = 1'($urandom);
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; digits = 16'h0; dp_in = 4'h0; blink_mask = 4'h0; blink_en = 1'b0;

        // Reset with arbitrary inputs, then scan order and frame coherency.
        do_reset(3);
        digits = 16'h1234; dp_in = 4'h0; blink_mask = 4'h0; blink_en = 1'b0;
        rst_n = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            step();
            case (c)
                1:  begin chk("scan_c1_sel", 32'(dig_sel), 32'hE); chk("scan_c1_seg", 32'(seg_out), 32'h19); end
                4:  chk("scan_c4_dead", 32'(dig_sel), 32'hF);
                5:  chk("scan_c5_seg", 32'(seg_out), 32'h30);
                9:  chk("coh_d2_old", 32'(seg_out), 32'h24);
                13: chk("coh_d3_old", 32'(seg_out), 32'h79);
                17: begin chk("scan_c17_fs", 32'(frame_start), 32'h1); chk("coh_f1_d0", 32'(seg_out), 32'h00); end
                21: chk("coh_f1_d1", 32'(seg_out), 32'h78);
                25: chk("coh_f1_d2", 32'(seg_out), 32'h02);
                29: chk("coh_f1_d3", 32'(seg_out), 32'h12);
                default: ;
            endcase
            if (c == 6) digits = 16'h5678;
        end

        // Blink on digit 0, then blink disabled, then decimal point.
        do_reset(1);
        digits = 16'h1234; blink_mask = 4'b0001; blink_en = 1'b1; dp_in = 4'h0;
        rst_n = 1'b1;
        for (int c = 1; c <= 5 * FR; c++) begin
            step();
            if (c == 2 * FR + 1) chk("blink_off_f2", 32'(dig_sel), 32'hF);
            if (c == 1)          chk("blink_on_f0", 32'(dig_sel), 32'hE);
        end
        blink_en = 1'b0;
        for (int c = 0; c < 4 * FR; c++) step();
        dp_in = 4'b0100;
        for (int c = 0; c < 2 * FR; c++) step();

        // Mid-frame reset during digit 2 with blink active.
        blink_en = 1'b1;
        for (int c = 0; c < 3 * FR && cur_idx != 2; c++) step();
        chk("midrst_reached_idx2", 32'(cur_idx), 32'd2);
        rst_n = 1'b0;
        step();
        chk("midrst_off_sel", 32'(dig_sel), 32'hF);
        rst_n = 1'b1;
        step();
        chk("midrst_restart_fs", 32'(frame_start), 32'h1);
        chk("midrst_restart_sel", 32'(dig_sel), 32'hE);
        for (int c = 0; c < 2 * FR; c++) step();

        // Random traffic with sporadic resets.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 7) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
